// File: rtl/debug_pkg.sv
// debug_pkg: shared types and constants for the debug program loader.
//   loader_state_e : loader FSM states
//   NOP_INSTR      : addi x0,x0,0, returned for out-of-range fetches
//   DEBUG_AW       : width of the debug/fetch word-index buses
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2,
    RUN    = 2'd3
  } loader_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          DEBUG_AW  = 32;

endpackage

// File: rtl/imem_1r1w.sv
// imem_1r1w: DEPTH x 32 instruction RAM, one sync write port, one sync read
// port with 1-cycle latency. The storage array is not reset; only the read
// data register is, so the fetch output has a defined reset value.
//   clk, nrst           : clock, async active-low reset (read register only)
//   we, waddr, wdata    : write port
//   re, raddr, rdata    : read port; rdata updates only when re, else holds
module imem_1r1w #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/debug_loader.sv
// debug_loader: receives the debug module's word stream into a local
// instruction RAM, holds the core idle until START, then serves fetches.
//   clk, nrst                          : clock, async active-low reset
//   DEBUG_SIG/DEBUG_addr/DEBUG_instr   : load strobe, word index, word
//   START                              : release request (LOADED only)
//   fetch_req/fetch_addr               : core fetch request, word index
//   fetch_instr/fetch_valid/fetch_fault: fetch result one cycle later
//   core_run                           : high in RUN
//   load_count                         : words accepted, saturates at DEPTH
//   load_err                           : sticky out-of-range load seen
module debug_loader
  import debug_pkg::*;
#(
  parameter  int          DEPTH = 256,
  parameter  logic [31:0] NOP   = NOP_INSTR,
  localparam int          AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                DEBUG_SIG,
  input  logic [DEBUG_AW-1:0] DEBUG_addr,
  input  logic [31:0]         DEBUG_instr,
  input  logic                START,
  input  logic                fetch_req,
  input  logic [DEBUG_AW-1:0] fetch_addr,
  output logic [31:0]         fetch_instr,
  output logic                fetch_valid,
  output logic                fetch_fault,
  output logic                core_run,
  output logic [AW:0]         load_count,
  output logic                load_err
);

  loader_state_e state_q, state_d;

  // Full-width compares: high address bits must never alias into the RAM.
  logic wr_in_range, rd_in_range;
  assign wr_in_range = DEBUG_addr < DEBUG_AW'(DEPTH);
  assign rd_in_range = fetch_addr < DEBUG_AW'(DEPTH);

  logic loading, load_acc, wr_en, fetch_acc, rd_en;
  assign loading   = (state_q == IDLE) || (state_q == LOAD);
  assign load_acc  = loading && DEBUG_SIG;
  assign wr_en     = load_acc && wr_in_range;
  assign fetch_acc = core_run && fetch_req;
  assign rd_en     = fetch_acc && rd_in_range;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (DEBUG_SIG)  state_d = LOAD;
      LOAD:   if (!DEBUG_SIG) state_d = LOADED;
      LOADED: if (START)      state_d = RUN;
      RUN:                    state_d = RUN;
      default:                state_d = IDLE;
    endcase
  end

  logic [31:0] rd_data;

  imem_1r1w #(.DEPTH(DEPTH)) u_imem (
    .clk   (clk),
    .nrst  (nrst),
    .we    (wr_en),
    .waddr (DEBUG_addr[AW-1:0]),
    .wdata (DEBUG_instr),
    .re    (rd_en),
    .raddr (fetch_addr[AW-1:0]),
    .rdata (rd_data)
  );

  // last_oob remembers whether the most recent accepted fetch was out of
  // range, so fetch_instr keeps showing NOP on idle cycles after a fault
  // while fetch_fault itself drops back to 0.
  logic last_oob;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      core_run    <= 1'b0;
      load_count  <= '0;
      load_err    <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      last_oob    <= 1'b0;
    end else begin
      core_run    <= (state_d == RUN);
      fetch_valid <= fetch_acc;
      fetch_fault <= fetch_acc && !rd_in_range;
      if (fetch_acc) last_oob <= !rd_in_range;
      if (wr_en && (load_count != (AW+1)'(DEPTH)))
        load_count <= load_count + 1'b1;
      if (load_acc && !wr_in_range)
        load_err <= 1'b1;
    end
  end

  assign fetch_instr = last_oob ? NOP : rd_data;

endmodule

// File: tb/tb_debug_loader.sv
module tb_debug_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOPW  = 32'h0000_0013;

  logic        clk, nrst;
  logic        DEBUG_SIG, START, fetch_req;
  logic [31:0] DEBUG_addr, DEBUG_instr, fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_valid, fetch_fault, core_run, load_err;
  logic [8:0]  load_count;

  debug_loader dut (
    .clk(clk), .nrst(nrst),
    .DEBUG_SIG(DEBUG_SIG), .DEBUG_addr(DEBUG_addr), .DEBUG_instr(DEBUG_instr),
    .START(START), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .fetch_fault(fetch_fault),
    .core_run(core_run), .load_count(load_count), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model at the level of the loader's rules.
  typedef enum int {M_IDLE, M_LOAD, M_LOADED, M_RUN} mstate_t;
  mstate_t     m_st;
  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  int          m_cnt;
  bit          m_err;
  logic [31:0] e_instr;
  bit          e_known, e_valid, e_fault;
  int          wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".run"},   32'(core_run),    32'(m_st == M_RUN));
    chk({tag, ".cnt"},   32'(load_count),  32'(m_cnt));
    chk({tag, ".err"},   32'(load_err),    32'(m_err));
    chk({tag, ".valid"}, 32'(fetch_valid), 32'(e_valid));
    chk({tag, ".fault"}, 32'(fetch_fault), 32'(e_fault));
    if (e_known) chk({tag, ".instr"}, fetch_instr, e_instr);
  endtask

  // Async reset asserted away from the clock edge; outputs checked before
  // any edge arrives, then released mid-cycle.
  task automatic do_reset(input string tag);
    nrst = 1'b0; DEBUG_SIG = 1'b0; START = 1'b0; fetch_req = 1'b0;
    #2;
    m_st = M_IDLE; m_cnt = 0; m_err = 0;
    e_instr = '0; e_known = 1; e_valid = 0; e_fault = 0;
    check_all(tag);
    @(posedge clk); @(posedge clk);
    #3 nrst = 1'b1;
  endtask

  task automatic cyc(input logic sig, input logic [31:0] a, input logic [31:0] d,
                     input logic st, input logic fr, input logic [31:0] fa,
                     input string tag);
    DEBUG_SIG = sig; DEBUG_addr = a; DEBUG_instr = d;
    START = st; fetch_req = fr; fetch_addr = fa;
    @(posedge clk);
    if (m_st == M_RUN && fr) begin
      e_valid = 1;
      if (fa < DEPTH) begin
        e_fault = 0; e_instr = m_mem[fa[7:0]]; e_known = m_wr[fa[7:0]];
      end else begin
        e_fault = 1; e_instr = NOPW; e_known = 1;
      end
    end else begin
      e_valid = 0; e_fault = 0;
    end
    if (sig && (m_st == M_IDLE || m_st == M_LOAD)) begin
      if (a < DEPTH) begin
        m_mem[a[7:0]] = d; m_wr[a[7:0]] = 1; wq.push_back(int'(a));
        if (m_cnt < DEPTH) m_cnt++;
      end else m_err = 1;
    end
    case (m_st)
      M_IDLE:   if (sig)  m_st = M_LOAD;
      M_LOAD:   if (!sig) m_st = M_LOADED;
      M_LOADED: if (st)   m_st = M_RUN;
      default:  ;
    endcase
    #1;
    check_all(tag);
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d, input string tag);
    cyc(1'b1, a, d, 1'b0, 1'b0, '0, tag);
  endtask
  task automatic idle(input string tag);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, tag);
  endtask
  task automatic go(input string tag);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0, tag);
  endtask
  task automatic fetch(input logic [31:0] fa, input string tag);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, fa, tag);
  endtask

  initial begin
    logic [31:0] w0, a, fa;
    nrst = 1'b1; DEBUG_SIG = 0; START = 0; fetch_req = 0;
    DEBUG_addr = '0; DEBUG_instr = '0; fetch_addr = '0;
    #1;
    do_reset("t0_reset");

    // 1: straight load of 15 words, release, read them back in order
    for (int i = 0; i < 15; i++) ld(32'(i), $urandom, "t1_load");
    idle("t1_end");
    go("t1_start");
    chk("t1_run_after_start", 32'(core_run), 32'd1);
    chk("t1_count15", 32'(load_count), 32'd15);
    for (int i = 0; i < 15; i++) fetch(32'(i), "t1_fetch");
    idle("t1_hold");

    // 2: START in IDLE and in LOAD is not latched
    do_reset("t2_reset");
    go("t2_start_idle");
    for (int i = 0; i < 5; i++) ld(32'(i), $urandom, "t2_load");
    cyc(1'b1, 32'd5, $urandom, 1'b1, 1'b0, '0, "t2_start_in_load");
    idle("t2_end");
    chk("t2_not_run", 32'(core_run), 32'd0);
    idle("t2_wait");
    go("t2_start");

    // 3: out-of-range load and fetch
    do_reset("t3_reset");
    ld(32'd10, $urandom, "t3_load");
    ld(32'd256, $urandom, "t3_oob256");
    ld(32'h0100_0007, $urandom, "t3_oob_nowrap");
    ld(32'd7, $urandom, "t3_load7");
    idle("t3_end");
    chk("t3_err_sticky", 32'(load_err), 32'd1);
    chk("t3_count", 32'(load_count), 32'd2);
    go("t3_start");
    fetch(32'd256, "t3_fetch256");
    chk("t3_nop", fetch_instr, 32'h0000_0013);
    fetch(32'd10, "t3_fetch10");
    fetch(32'h0100_0007, "t3_fetch_hi");
    idle("t3_hold_nop");
    fetch(32'd7, "t3_fetch7");

    // 4: duplicate address, last write wins, both count
    do_reset("t4_reset");
    ld(32'd3, 32'hAAAA_0033, "t4_w1");
    ld(32'd3, 32'hBBBB_0033, "t4_w2");
    idle("t4_end");
    go("t4_start");
    fetch(32'd3, "t4_fetch3");
    chk("t4_last_wins", fetch_instr, 32'hBBBB_0033);
    chk("t4_count2", 32'(load_count), 32'd2);

    // 5: load strobe in LOADED is ignored
    do_reset("t5_reset");
    w0 = $urandom;
    ld(32'd0, w0, "t5_w0");
    ld(32'd1, $urandom, "t5_w1");
    idle("t5_end");
    ld(32'd0, 32'hDEAD_0033, "t5_late");
    idle("t5_still_loaded");
    go("t5_start");
    fetch(32'd0, "t5_fetch0");
    chk("t5_orig", fetch_instr, w0);

    // 6: reset mid-load, then a randomized session
    do_reset("t6_reset");
    for (int i = 0; i < 7; i++) ld(32'(i + 20), $urandom, "t6_partial");
    do_reset("t6_midreset");
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'd256 + 32'($urandom_range(0, 5000));
      else                           a = 32'($urandom_range(0, DEPTH - 1));
      cyc(1'b1, a, $urandom, 1'($urandom), 1'b0, '0, "t6_load");
    end
    idle("t6_end");
    go("t6_start");
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) fa = 32'd256 + 32'($urandom);
      else                           fa = 32'(wq[$urandom_range(0, wq.size() - 1)]);
      cyc(1'($urandom), 32'($urandom_range(0, DEPTH - 1)), $urandom, 1'($urandom),
          ($urandom_range(0, 3) != 0), fa, "t6_run");
    end

    // 7: load_count saturates at DEPTH
    do_reset("t7_reset");
    for (int i = 0; i < DEPTH + 4; i++)
      ld(32'($urandom_range(0, DEPTH - 1)), $urandom, "t7_load");
    chk("t7_sat", 32'(load_count), 32'd256);
    idle("t7_end");
    go("t7_start");
    for (int i = 0; i < 8; i++) fetch(32'(wq[$urandom_range(0, wq.size() - 1)]), "t7_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
